// File: rtl/fm_copy_engine.sv
// fm_copy_engine
//   Moves one feature-map tile from the IFM buffer to the OFM buffer. It
//   launches the route/upsample address sequencer and then consumes its
//   read and write address streams.
//   - Each sequencer read is reissued to the IFM read port one cycle later.
//   - Each sequencer write address waits in a small FIFO until its read data
//     returns RD_LAT cycles after the IFM read.
//   - The address and data are then written to the OFM port together.
//   - The block flags FIFO overflow, FIFO underflow and write-count mismatch
//     with a sticky error bit.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   q_mv_start, q_total_words      start pulse and expected OFM write count
//   o_mv_busy, o_mv_done, o_mv_err status back to the top-level controller
//   o_as_start, i_as_done          sequencer launch pulse and its done pulse
//   i_as_rd_vld, i_as_rd_addr      sequencer read stream
//   i_as_wr_vld, i_as_wr_addr      sequencer write stream (one cycle behind)
//   o_ifm_rd_en, o_ifm_rd_addr     IFM buffer read port
//   i_ifm_rd_data                  IFM read data, RD_LAT cycles after enable
//   o_ofm_wr_en, o_ofm_wr_addr,
//   o_ofm_wr_data                  OFM buffer write port
module fm_copy_engine #(
    parameter int IFM_AW      = 17,
    parameter int OFM_AW      = 17,
    parameter int DW          = 256,
    parameter int RD_LAT      = 1,
    parameter int AFIFO_DEPTH = 8,
    parameter int W_CNT       = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_mv_start,
    input  logic [W_CNT-1:0]  q_total_words,
    output logic              o_mv_busy,
    output logic              o_mv_done,
    output logic              o_mv_err,
    output logic              o_as_start,
    input  logic              i_as_done,
    input  logic              i_as_rd_vld,
    input  logic [IFM_AW-1:0] i_as_rd_addr,
    input  logic              i_as_wr_vld,
    input  logic [OFM_AW-1:0] i_as_wr_addr,
    output logic              o_ifm_rd_en,
    output logic [IFM_AW-1:0] o_ifm_rd_addr,
    input  logic [DW-1:0]     i_ifm_rd_data,
    output logic              o_ofm_wr_en,
    output logic [OFM_AW-1:0] o_ofm_wr_addr,
    output logic [DW-1:0]     o_ofm_wr_data
);

    localparam int PW = $clog2(AFIFO_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(AFIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [OFM_AW-1:0] fifo_mem [AFIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic              fifo_empty, fifo_full;
    logic              push, pop, overflow, underflow;

    logic [RD_LAT-1:0] dv_pipe;
    logic              dv;
    logic              pipe_empty;

    logic [W_CNT-1:0]  wr_cnt, total_q;
    logic              start_acc;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_FULL);

    // dv is high in the cycle in which i_ifm_rd_data is valid.
    assign dv         = dv_pipe[RD_LAT-1];
    assign pipe_empty = !o_ifm_rd_en && (dv_pipe == '0);

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push      = i_as_wr_vld && !fifo_full;
    assign overflow  = i_as_wr_vld && fifo_full;
    assign pop       = dv && !fifo_empty;
    assign underflow = dv && fifo_empty;

    assign o_mv_busy  = (state != IDLE);
    assign o_mv_done  = (state == DONE);
    assign o_as_start = (state == LAUNCH);

    // FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        unique case (state)
            IDLE: begin
                if (q_mv_start) begin
                    start_acc = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:  state_nxt = RUN;
            RUN:     if (i_as_done) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty && fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read issue and data-valid tracking (not gated by state)
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ifm_rd_en   <= 1'b0;
            o_ifm_rd_addr <= '0;
            dv_pipe       <= '0;
        end else begin
            o_ifm_rd_en   <= i_as_rd_vld;
            o_ifm_rd_addr <= i_as_rd_addr;
            dv_pipe[0]    <= o_ifm_rd_en;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                dv_pipe[i] <= dv_pipe[i-1];
            end
        end
    end

    // Write-address FIFO
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= i_as_wr_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Write issue
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ofm_wr_en   <= 1'b0;
            o_ofm_wr_addr <= '0;
            o_ofm_wr_data <= '0;
        end else begin
            o_ofm_wr_en <= pop;
            if (pop) begin
                o_ofm_wr_addr <= fifo_mem[rd_ptr];
                o_ofm_wr_data <= i_ifm_rd_data;
            end
        end
    end

    // Counters and sticky error. A start clears, but a concurrent error event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            total_q  <= '0;
            o_mv_err <= 1'b0;
        end else begin
            if (start_acc) begin
                wr_cnt  <= '0;
                total_q <= q_total_words;
            end else if (pop && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end

            if (start_acc) o_mv_err <= 1'b0;
            if (overflow || underflow || ((state == DONE) && (wr_cnt != total_q)))
                o_mv_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fm_copy_engine.sv
// Bench for fm_copy_engine. The sequencer and the IFM buffer are driven from
// the bench. A queue/history reference model predicts every output on every
// cycle, and a few literal expectations pin the model itself.
module tb_fm_copy_engine;

    localparam int IFM_AW = 17;
    localparam int OFM_AW = 17;
    localparam int DW     = 256;
    localparam int LAT    = 3;
    localparam int DEPTH  = 8;
    localparam int W_CNT  = 24;
    localparam int HMAX   = 8192;
    localparam longint CNT_MAX = (64'd1 << W_CNT) - 1;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_DONE   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              q_mv_start;
    logic [W_CNT-1:0]  q_total_words;
    logic              o_mv_busy, o_mv_done, o_mv_err, o_as_start;
    logic              i_as_done, i_as_rd_vld, i_as_wr_vld;
    logic [IFM_AW-1:0] i_as_rd_addr;
    logic [OFM_AW-1:0] i_as_wr_addr;
    logic              o_ifm_rd_en;
    logic [IFM_AW-1:0] o_ifm_rd_addr;
    logic [DW-1:0]     i_ifm_rd_data;
    logic              o_ofm_wr_en;
    logic [OFM_AW-1:0] o_ofm_wr_addr;
    logic [DW-1:0]     o_ofm_wr_data;

    fm_copy_engine #(
        .IFM_AW(IFM_AW), .OFM_AW(OFM_AW), .DW(DW), .RD_LAT(LAT),
        .AFIFO_DEPTH(DEPTH), .W_CNT(W_CNT)
    ) dut (
        .clk(clk), .rst(rst),
        .q_mv_start(q_mv_start), .q_total_words(q_total_words),
        .o_mv_busy(o_mv_busy), .o_mv_done(o_mv_done), .o_mv_err(o_mv_err),
        .o_as_start(o_as_start), .i_as_done(i_as_done),
        .i_as_rd_vld(i_as_rd_vld), .i_as_rd_addr(i_as_rd_addr),
        .i_as_wr_vld(i_as_wr_vld), .i_as_wr_addr(i_as_wr_addr),
        .o_ifm_rd_en(o_ifm_rd_en), .o_ifm_rd_addr(o_ifm_rd_addr),
        .i_ifm_rd_data(i_ifm_rd_data),
        .o_ofm_wr_en(o_ofm_wr_en), .o_ofm_wr_addr(o_ofm_wr_addr),
        .o_ofm_wr_data(o_ofm_wr_data)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int                cyc = 0;
    int                valid_from = 0;
    bit                hist_vld  [HMAX];
    logic [IFM_AW-1:0] hist_addr [HMAX];
    logic [OFM_AW-1:0] mq[$];
    int                phase = P_IDLE;
    longint            m_cnt = 0;
    longint            m_total = 0;
    int                max_occ = 0;

    logic              e_rd_en, e_wr_en, e_busy, e_done, e_as_start, e_err;
    logic [IFM_AW-1:0] e_rd_addr;
    logic [OFM_AW-1:0] e_wr_addr;
    logic [DW-1:0]     e_wr_data;
    bit                chk_w;

    // observations of the DUT used by the literal pins
    int                n_wr_obs = 0, n_done_obs = 0, n_start_obs = 0;
    bit                fw_seen, fr_seen;
    int                fw_cycle, fr_cycle;
    logic [OFM_AW-1:0] fw_addr;
    logic [DW-1:0]     fw_data;

    function automatic logic [DW-1:0] data_of(input logic [IFM_AW-1:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++)
            r[k*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(k) * 32'h0100_0193;
        return r;
    endfunction

    function automatic bit was_read(input int k);
        if (k < 0 || k < valid_from) return 1'b0;
        return hist_vld[k];
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        q_mv_start   = 1'b0;
        i_as_done    = 1'b0;
        i_as_rd_vld  = 1'b0;
        i_as_wr_vld  = 1'b0;
        i_as_rd_addr = IFM_AW'($urandom());
        i_as_wr_addr = OFM_AW'($urandom());
    endtask

    // One clock: play the IFM buffer, advance the model, and compare every output after the edge.
    task automatic step();
        bit dv, drained, set_err;
        int pre, src;
        if (cyc >= HMAX) begin
            $display("FAIL history_overflow cycle %0d", cyc);
            $fatal(1, "history exhausted");
        end
        src = cyc - 1 - LAT;
        dv  = was_read(src);
        if (dv) i_ifm_rd_data = data_of(hist_addr[src]);
        else    i_ifm_rd_data = {8{32'($urandom())}};
        hist_vld[cyc]  = i_as_rd_vld && !rst;
        hist_addr[cyc] = i_as_rd_addr;
        chk_w = 1'b0;

        if (rst) begin
            e_rd_en = 0; e_rd_addr = '0; e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0;
            e_busy = 0; e_done = 0; e_as_start = 0; e_err = 0;
            mq.delete();
            phase = P_IDLE; m_cnt = 0; m_total = 0;
            valid_from = cyc + 1;
            chk_w = 1'b1;
        end else begin
            set_err = 1'b0;
            pre     = mq.size();
            drained = (pre == 0);
            for (int k = cyc - 1 - LAT; k <= cyc - 1; k++)
                if (was_read(k)) drained = 1'b0;
            e_rd_en   = i_as_rd_vld;
            e_rd_addr = i_as_rd_addr;
            e_wr_en   = 1'b0;
            if (dv) begin
                if (pre > 0) begin
                    e_wr_en   = 1'b1;
                    e_wr_addr = mq.pop_front();
                    e_wr_data = data_of(hist_addr[src]);
                    chk_w     = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    set_err = 1'b1;
                end
            end
            if (i_as_wr_vld) begin
                if (pre == DEPTH) set_err = 1'b1;
                else              mq.push_back(i_as_wr_addr);
            end
            if (mq.size() > max_occ) max_occ = mq.size();
            case (phase)
                P_IDLE: if (q_mv_start) begin
                    m_total = longint'(q_total_words);
                    m_cnt   = 0;
                    e_err   = 1'b0;
                    phase   = P_LAUNCH;
                end
                P_LAUNCH: phase = P_RUN;
                P_RUN:    if (i_as_done) phase = P_DRAIN;
                P_DRAIN:  if (drained) phase = P_DONE;
                default: begin
                    if (m_cnt != m_total) set_err = 1'b1;
                    phase = P_IDLE;
                end
            endcase
            if (set_err) e_err = 1'b1;
            e_busy     = (phase != P_IDLE);
            e_done     = (phase == P_DONE);
            e_as_start = (phase == P_LAUNCH);
        end

        @(posedge clk);
        #1;
        chk("ifm_rd_en",   DW'(o_ifm_rd_en),   DW'(e_rd_en));
        chk("ifm_rd_addr", DW'(o_ifm_rd_addr), DW'(e_rd_addr));
        chk("ofm_wr_en",   DW'(o_ofm_wr_en),   DW'(e_wr_en));
        if (chk_w) begin
            chk("ofm_wr_addr", DW'(o_ofm_wr_addr), DW'(e_wr_addr));
            chk("ofm_wr_data", o_ofm_wr_data, e_wr_data);
        end
        chk("mv_busy",  DW'(o_mv_busy),  DW'(e_busy));
        chk("mv_done",  DW'(o_mv_done),  DW'(e_done));
        chk("as_start", DW'(o_as_start), DW'(e_as_start));
        chk("mv_err",   DW'(o_mv_err),   DW'(e_err));

        if (o_ofm_wr_en) begin
            n_wr_obs++;
            if (!fw_seen) begin
                fw_seen  = 1'b1;
                fw_cycle = cyc + 1;
                fw_addr  = o_ofm_wr_addr;
                fw_data  = o_ofm_wr_data;
            end
        end
        if (o_mv_done)  n_done_obs++;
        if (o_as_start) n_start_obs++;
        cyc++;
    endtask

    // Sequencer stand-in. Write addresses lag reads by one cycle. skip_wr drops
    // one write valid, restart_at re-pulses start mid-run, and rst_after_wr
    // resets after that many writes.
    task automatic transfer(input int n, input int total, input int skip_wr, input int gap_pct,
                            input bit route, input int restart_at, input int rst_after_wr,
                            output bit aborted);
        bit                pend, pend_n;
        int                pend_idx, idx_n, issued, budget;
        logic [OFM_AW-1:0] pend_wa, wa_n;
        aborted = 1'b0;
        fw_seen = 1'b0;
        fr_seen = 1'b0;
        idle_inputs();
        q_mv_start    = 1'b1;
        q_total_words = W_CNT'(total);
        step();
        q_mv_start    = 1'b0;
        q_total_words = W_CNT'($urandom());
        step();
        step();
        issued = 0; pend = 1'b0; pend_idx = 0; pend_wa = '0;
        while (issued < n || pend) begin
            if (rst_after_wr > 0 && m_cnt >= rst_after_wr) begin
                idle_inputs();
                rst = 1'b1;
                step();
                rst = 1'b0;
                aborted = 1'b1;
                return;
            end
            q_mv_start   = (restart_at >= 0 && issued == restart_at);
            i_as_wr_vld  = pend && (pend_idx != skip_wr);
            i_as_wr_addr = pend ? pend_wa : OFM_AW'($urandom());
            pend_n = 1'b0; idx_n = 0; wa_n = '0;
            if (issued < n && $urandom_range(99) >= gap_pct) begin
                i_as_rd_vld  = 1'b1;
                i_as_rd_addr = route ? IFM_AW'(100 + issued) : IFM_AW'($urandom());
                if (!fr_seen) begin
                    fr_seen  = 1'b1;
                    fr_cycle = cyc;
                end
                pend_n = 1'b1;
                idx_n  = issued;
                wa_n   = route ? OFM_AW'((issued / 2) * 4 + issued % 2) : OFM_AW'($urandom());
                issued++;
            end else begin
                i_as_rd_vld  = 1'b0;
                i_as_rd_addr = IFM_AW'($urandom());
            end
            step();
            pend = pend_n; pend_idx = idx_n; pend_wa = wa_n;
        end
        idle_inputs();
        i_as_done = 1'b1;
        step();
        i_as_done = 1'b0;
        budget = 0;
        while (phase != P_IDLE && budget < 100) begin
            step();
            budget++;
        end
        checks++;
        if (phase != P_IDLE) begin
            errors++;
            $display("FAIL done_timeout cycle %0d got phase %0d expected %0d", cyc, phase, P_IDLE);
        end
    endtask

    initial begin : main
        int  d0, s0, w0;
        bit  ab;
        rst = 1'b1;
        q_total_words = '0;
        idle_inputs();
        step();
        step();
        chk("rst_busy",  DW'(o_mv_busy),   DW'(0));
        chk("rst_err",   DW'(o_mv_err),    DW'(0));
        chk("rst_wr_en", DW'(o_ofm_wr_en), DW'(0));
        chk("rst_rd_en", DW'(o_ifm_rd_en), DW'(0));
        rst = 1'b0;
        step();

        // route 2x2 ch=2: reads 100..107, writes 0,1,4,5,8,9,12,13
        d0 = n_done_obs; w0 = n_wr_obs;
        transfer(8, 8, -1, 0, 1'b1, -1, 0, ab);
        chk("route_writes",     DW'(n_wr_obs - w0),        DW'(8));
        chk("route_done_cnt",   DW'(n_done_obs - d0),      DW'(1));
        chk("route_latency",    DW'(fw_cycle - fr_cycle),  DW'(5));
        chk("route_first_addr", DW'(fw_addr),              DW'(0));
        chk("route_first_data", fw_data,                   data_of(IFM_AW'(100)));
        chk("route_err",        DW'(o_mv_err),             DW'(0));

        // upsample-like stream of 32 reads with gaps
        max_occ = 0; w0 = n_wr_obs;
        transfer(32, 32, -1, 20, 1'b0, -1, 0, ab);
        chk("ups_writes",    DW'(n_wr_obs - w0), DW'(32));
        chk("ups_occ_le_4",  DW'(max_occ <= 4),  DW'(1));
        chk("ups_err",       DW'(o_mv_err),      DW'(0));

        // one write valid missing
        d0 = n_done_obs; w0 = n_wr_obs;
        transfer(8, 8, 3, 0, 1'b1, -1, 0, ab);
        chk("miss_writes",   DW'(n_wr_obs - w0),   DW'(7));
        chk("miss_done_cnt", DW'(n_done_obs - d0), DW'(1));
        chk("miss_err",      DW'(o_mv_err),        DW'(1));

        // count mismatch, then a clean run clears err
        transfer(8, 10, -1, 0, 1'b1, -1, 0, ab);
        chk("short_err", DW'(o_mv_err), DW'(1));
        transfer(8, 8, -1, 10, 1'b1, -1, 0, ab);
        chk("clean_after_short_err", DW'(o_mv_err), DW'(0));

        // start pulsed during RUN is ignored
        d0 = n_done_obs; s0 = n_start_obs;
        transfer(16, 16, -1, 10, 1'b0, 5, 0, ab);
        chk("restart_as_start_cnt", DW'(n_start_obs - s0), DW'(1));
        chk("restart_done_cnt",     DW'(n_done_obs - d0),  DW'(1));
        chk("restart_err",          DW'(o_mv_err),         DW'(0));

        // reset mid-run after 5 writes
        d0 = n_done_obs;
        transfer(16, 16, -1, 0, 1'b1, -1, 5, ab);
        chk("rst_aborted",     DW'(ab),          DW'(1));
        chk("rst_mid_busy",    DW'(o_mv_busy),   DW'(0));
        chk("rst_mid_wr_en",   DW'(o_ofm_wr_en), DW'(0));
        idle_inputs();
        for (int i = 0; i < 8; i++) step();
        chk("rst_mid_no_done", DW'(n_done_obs - d0), DW'(0));
        transfer(8, 8, -1, 0, 1'b1, -1, 0, ab);
        chk("after_rst_err",   DW'(o_mv_err), DW'(0));

        // FIFO overflow: nine pushes with no reads
        idle_inputs();
        for (int i = 0; i < DEPTH + 1; i++) begin
            i_as_wr_vld  = 1'b1;
            i_as_wr_addr = OFM_AW'($urandom());
            step();
        end
        idle_inputs();
        step();
        chk("ovf_err", DW'(o_mv_err), DW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ovf_rst_err", DW'(o_mv_err), DW'(0));
        step();

        // a few random transfers
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(4, 24);
            transfer(n, n, -1, 25, 1'b0, -1, 0, ab);
            chk("rand_err", DW'(o_mv_err), DW'(0));
        end

        idle_inputs();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
